// File: rtl/keypad_sum_ctrl_if.sv
// Keypad/display bundle for keypad_sum_ctrl.
// key_strobe_o is a one-cycle pulse with no back-pressure. key_code_o is valid while the strobe is high and is held afterwards.
interface keypad_sum_ctrl_if;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [15:0] bin_o;
  logic [1:0]  state_o;
  logic        key_strobe_o;
  logic [3:0]  key_code_o;

  modport master (
    input  row_i,
    output col_o, bin_o, state_o, key_strobe_o, key_code_o
  );

  modport slave (
    output row_i,
    input  col_o, bin_o, state_o, key_strobe_o, key_code_o
  );
endinterface

// File: rtl/keypad_sum_ctrl.sv
// 4x4 keypad scanner with sweep debounce, feeding a two-operand decimal adder.
// bin_o shows operand A, then operand B, then A+B.
module keypad_sum_ctrl #(
  parameter int SCAN_CYCLES    = 27000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int MAX_DIGITS     = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  keypad_sum_ctrl_if.master  bus
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);
  localparam logic [1:0]    MAXD      = 2'(MAX_DIGITS);
  localparam logic [4:0]    NONE      = 5'h10;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    SHOW_SUM = 2'b10
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  function automatic logic [9:0] append_digit(input logic [9:0] op, input logic [3:0] d);
    return (op << 3) + (op << 1) + {6'b0, d};
  endfunction

  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    col_q;
  logic [1:0]    hits_q;
  logic [3:0]    hit_code_q;
  logic [4:0]    cand_q, stable_q;
  logic [DW-1:0] cand_cnt_q;
  logic          key_strobe_q;
  logic [3:0]    key_code_q;

  logic [1:0]    col_hits, tot_hits;
  logic [3:0]    col_code, tot_code;
  logic [4:0]    sweep_res;
  logic          dwell_end, sweep_done, deb_ok;
  logic [DW-1:0] deb_cnt_n;

  // Hit counts saturate at 2: anything beyond "exactly one key" is NONE.
  always_comb begin
    col_hits = 2'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_code = key_map(2'(r), col_idx);
      end
    end
    if (col_hits == 2'd2 || hits_q == 2'd2 || (col_hits == 2'd1 && hits_q == 2'd1))
      tot_hits = 2'd2;
    else
      tot_hits = hits_q | col_hits;
    tot_code   = (col_hits != 2'd0) ? col_code : hit_code_q;
    sweep_res  = (tot_hits == 2'd1) ? {1'b0, tot_code} : NONE;
    dwell_end  = (scan_cnt == SCAN_LAST);
    sweep_done = dwell_end && (col_idx == 2'd3);
    if (sweep_res == cand_q)
      deb_cnt_n = (cand_cnt_q >= DEB_MAX) ? cand_cnt_q : cand_cnt_q + DW'(1);
    else
      deb_cnt_n = DW'(1);
    deb_ok = (deb_cnt_n >= DEB_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_s1       <= 4'hF;
      row_s2       <= 4'hF;
      scan_cnt     <= '0;
      col_idx      <= 2'd0;
      col_q        <= 4'b1110;
      hits_q       <= 2'd0;
      hit_code_q   <= 4'h0;
      cand_q       <= NONE;
      cand_cnt_q   <= '0;
      stable_q     <= NONE;
      key_strobe_q <= 1'b0;
      key_code_q   <= 4'h0;
    end else begin
      row_s1       <= bus.row_i;
      row_s2       <= row_s1;
      key_strobe_q <= 1'b0;
      if (dwell_end) begin
        scan_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        col_q    <= {col_q[2:0], col_q[3]};
        if (sweep_done) begin
          hits_q     <= 2'd0;
          hit_code_q <= 4'h0;
          cand_q     <= sweep_res;
          cand_cnt_q <= deb_cnt_n;
          if (deb_ok) begin
            stable_q <= sweep_res;
            // Only a NONE->key transition is a press; key->key is not.
            if (stable_q == NONE && sweep_res != NONE) begin
              key_strobe_q <= 1'b1;
              key_code_q   <= sweep_res[3:0];
            end
          end
        end else begin
          hits_q     <= tot_hits;
          hit_code_q <= tot_code;
        end
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
    end
  end

  state_t      state_q, state_n;
  logic [9:0]  a_q, a_n, b_q, b_n;
  logic [1:0]  cnt_q, cnt_n;
  logic [15:0] bin_q, bin_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= 2'd0;
      bin_q   <= '0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      bin_q   <= bin_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    bin_n   = bin_q;
    if (key_strobe_q) begin
      if (key_code_q == 4'hE) begin
        state_n = ENTER_A;
        a_n     = '0;
        b_n     = '0;
        cnt_n   = 2'd0;
        bin_n   = '0;
      end else if (key_code_q <= 4'd9) begin
        case (state_q)
          ENTER_A: if (cnt_q < MAXD) begin
            a_n   = append_digit(a_q, key_code_q);
            cnt_n = cnt_q + 2'd1;
            bin_n = {6'b0, append_digit(a_q, key_code_q)};
          end
          ENTER_B: if (cnt_q < MAXD) begin
            b_n   = append_digit(b_q, key_code_q);
            cnt_n = cnt_q + 2'd1;
            bin_n = {6'b0, append_digit(b_q, key_code_q)};
          end
          SHOW_SUM: begin
            state_n = ENTER_A;
            a_n     = {6'b0, key_code_q};
            b_n     = '0;
            cnt_n   = 2'd1;
            bin_n   = {12'b0, key_code_q};
          end
          default: ;
        endcase
      end else if (key_code_q == 4'hF) begin
        case (state_q)
          ENTER_A: begin
            state_n = ENTER_B;
            b_n     = '0;
            cnt_n   = 2'd0;
            bin_n   = '0;
          end
          ENTER_B: begin
            state_n = SHOW_SUM;
            bin_n   = {5'b0, {1'b0, a_q} + {1'b0, b_q}};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.col_o        = col_q;
  assign bus.bin_o        = bin_q;
  assign bus.state_o      = state_q;
  assign bus.key_strobe_o = key_strobe_q;
  assign bus.key_code_o   = key_code_q;

endmodule

// File: tb/tb_keypad_sum_ctrl.sv
// Bench for keypad_sum_ctrl: keypad matrix model, arithmetic reference model,
// expected-response queue with an independent strobe monitor.
module tb_keypad_sum_ctrl;
  localparam int SC    = 4;
  localparam int DS    = 2;
  localparam int SWEEP = 4 * SC;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keypad_sum_ctrl_if bus ();

  keypad_sum_ctrl #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DS), .MAX_DIGITS(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // keypad matrix: pressed[r*4+c] shorts row r to column c
  logic [15:0] pressed;
  logic [3:0]  row_v;
  always_comb begin
    row_v = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !bus.col_o[c]) row_v[r] = 1'b0;
  end
  assign bus.row_i = row_v;

  int key_at [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  function automatic int pos_of(input int code);
    for (int i = 0; i < 16; i++) if (key_at[i] == code) return i;
    return 0;
  endfunction

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  int n_pushed = 0;
  int n_strobes = 0;
  logic [21:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: plain decimal arithmetic on integer operands
  int m_state, m_a, m_b, m_cnt, m_bin;

  function automatic void model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_cnt = 0; m_bin = 0;
  endfunction

  function automatic void model_key(input int code);
    logic [21:0] e;
    if (code == 14) begin
      model_reset();
    end else if (code <= 9) begin
      if (m_state == 2) begin
        m_state = 0; m_a = code; m_b = 0; m_cnt = 1; m_bin = code;
      end else if (m_cnt < 3) begin
        m_cnt++;
        if (m_state == 0) begin m_a = m_a * 10 + code; m_bin = m_a; end
        else begin m_b = m_b * 10 + code; m_bin = m_b; end
      end
    end else if (code == 15) begin
      if (m_state == 0) begin m_state = 1; m_b = 0; m_cnt = 0; m_bin = 0; end
      else if (m_state == 1) begin m_state = 2; m_bin = m_a + m_b; end
    end
    e = {m_state[1:0], m_bin[15:0], code[3:0]};
    exp_q.push_back(e);
    n_pushed++;
  endfunction

  // monitor
  logic        chk_pending = 1'b0;
  logic [21:0] cur;
  always @(negedge clk) begin
    if (rst) begin
      chk_pending = 1'b0;
    end else begin
      if (chk_pending) begin
        check("bin_after_key", int'(bus.bin_o), int'(cur[19:4]));
        check("state_after_key", int'(bus.state_o), int'(cur[21:20]));
        chk_pending = 1'b0;
      end
      if (bus.key_strobe_o) begin
        n_strobes++;
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("key_code", int'(bus.key_code_o), int'(cur[3:0]));
          chk_pending = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic press(input int code, input int hold_sweeps);
    pressed = 16'h0;
    pressed[pos_of(code)] = 1'b1;
    model_key(code);
    repeat (hold_sweeps * SWEEP) @(negedge clk);
    pressed = 16'h0;
    repeat (4 * SWEEP) @(negedge clk);
  endtask

  task automatic seq(input int k0, input int k1, input int k2, input int k3);
    int ks [4];
    ks = '{k0, k1, k2, k3};
    for (int i = 0; i < 4; i++) if (ks[i] >= 0) press(ks[i], 4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, int'(bus.col_o), 14);
    check({tag, "_bin"}, int'(bus.bin_o), 0);
    check({tag, "_state"}, int'(bus.state_o), 0);
    check({tag, "_strobe"}, int'(bus.key_strobe_o), 0);
  endtask

  task automatic check_rotation(input string tag);
    logic [3:0] exp_col;
    for (int i = 0; i < SWEEP; i++) begin
      exp_col = ~(4'b0001 << (i / SC));
      check({tag, "_rotation"}, int'(bus.col_o), int'(exp_col));
      @(negedge clk);
    end
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs(tag);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_rotation(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pressed = 16'h0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_code", int'(bus.key_code_o), 0);
    rst = 1'b0;
    check_rotation("post_reset");
    repeat (2 * SWEEP) @(negedge clk);

    // A = 123, '#', B = 877, '#'
    seq(1, 2, 3, -1);
    check("a_123", int'(bus.bin_o), 123);
    press(15, 4);
    check("enter_b_bin", int'(bus.bin_o), 0);
    check("enter_b_state", int'(bus.state_o), 1);
    seq(8, 7, 7, 15);
    check("sum_1000", int'(bus.bin_o), 1000);
    check("sum_state", int'(bus.state_o), 2);

    // reset mid-sweep
    repeat (7) @(negedge clk);
    mid_reset("mid_reset");

    // max operands
    seq(9, 9, 9, 15);
    seq(9, 9, 9, 15);
    check("sum_1998", int'(bus.bin_o), 1998);
    press(5, 4);
    check("restart_state", int'(bus.state_o), 0);
    check("restart_bin", int'(bus.bin_o), 5);

    // fourth digit ignored
    seq(14, 1, 2, 3);
    press(4, 4);
    check("digit_limit", int'(bus.bin_o), 123);

    // debounce
    pressed = 16'h0;
    pressed[pos_of(5)] = 1'b1;
    repeat (SWEEP - 4) @(negedge clk);
    pressed = 16'h0;
    repeat (4 * SWEEP) @(negedge clk);
    check("short_press_strobes", n_strobes, n_pushed);
    pressed[pos_of(1)] = 1'b1;
    pressed[pos_of(5)] = 1'b1;
    repeat (8 * SWEEP) @(negedge clk);
    pressed = 16'h0;
    repeat (4 * SWEEP) @(negedge clk);
    check("two_key_strobes", n_strobes, n_pushed);
    press(6, 20);
    check("long_hold_strobes", n_strobes, n_pushed);

    // '*' in ENTER_B clears
    seq(15, 4, 2, -1);
    check("b_42", int'(bus.bin_o), 42);
    press(14, 4);
    check("clear_state", int'(bus.state_o), 0);
    check("clear_bin", int'(bus.bin_o), 0);

    // reset while key 7 held
    pressed = 16'h0;
    pressed[pos_of(7)] = 1'b1;
    model_key(7);
    repeat (5 * SWEEP) @(negedge clk);
    check("held7_first_strobe", n_strobes, n_pushed);
    mid_reset("held_reset");
    model_key(7);
    repeat (5 * SWEEP) @(negedge clk);
    check("held7_after_reset_strobes", n_strobes, n_pushed);
    check("held7_bin", int'(bus.bin_o), 7);
    pressed = 16'h0;
    repeat (4 * SWEEP) @(negedge clk);

    // randomized entry
    for (int i = 0; i < 40; i++) begin
      int k;
      k = (i % 5 == 4) ? 15 : int'($urandom_range(0, 15));
      press(key_at[k[3:0]], int'($urandom_range(3, 5)));
    end
    check("random_strobes", n_strobes, n_pushed);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_bin", int'(bus.bin_o), m_bin);
    check("final_state", int'(bus.state_o), m_state);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
